// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// State enum, key code table indexed {row,col}, idle row pattern.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  localparam logic [3:0] ROW_IDLE = 4'b1110;

  // Entry 0 is row 0 / col 0; '*' maps to E, '#' to F.
  localparam logic [15:0][3:0] CODE_TBL = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, parameterised width, async active-low reset.
// Ports: clk, rst_n, d (async in), q (synchronised out).
module sync_2ff #(
  parameter int          W        = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, column debounce, key encode, dav level.
// Ports: clock, reset (async low), cols in, rows/dav/dataIn out.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       dav,
  output logic [3:0] dataIn
);

  localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_TICKS);

  logic [3:0] scol;

  sync_2ff #(
    .W      (4),
    .RST_VAL(4'hF)
  ) u_sync (
    .clk  (clock),
    .rst_n(reset),
    .d    (cols),
    .q    (scol)
  );

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  assign tick = (tick_cnt_q == TICK_MAX);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  state_t        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    rows_q, rows_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    data_q, data_d;
  logic          dav_q, dav_d;

  // Exactly one low column is a key; none or several is no key.
  logic       key_ok;
  logic [1:0] key_col;

  always_comb begin
    key_ok  = 1'b1;
    key_col = 2'd0;
    case (scol)
      4'b1110: key_col = 2'd0;
      4'b1101: key_col = 2'd1;
      4'b1011: key_col = 2'd2;
      4'b0111: key_col = 2'd3;
      default: key_ok  = 1'b0;
    endcase
  end

  logic          col_hi;
  logic [CW-1:0] cnt_inc;

  assign col_hi  = scol[cand_q];
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rows_d  = rows_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    // Registered from state so dataIn leads dav by one clock.
    dav_d   = (state_q == HELD) || (state_q == DB_RELEASE);
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (key_ok) begin
            cand_d  = key_col;
            cnt_d   = '0;
            state_d = DB_PRESS;
          end else begin
            row_d  = row_q + 2'd1;
            rows_d = {rows_q[2:0], rows_q[3]};
          end
        end
        DB_PRESS: begin
          if (key_ok && key_col == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              data_d  = CODE_TBL[{row_q, cand_q}];
              state_d = HELD;
            end
          end else begin
            state_d = SCAN;
          end
        end
        HELD: begin
          if (col_hi) begin
            cnt_d   = '0;
            state_d = DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (col_hi) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              state_d = SCAN;
              row_d   = row_q + 2'd1;
              rows_d  = {rows_q[2:0], rows_q[3]};
            end
          end else begin
            state_d = HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      state_q    <= SCAN;
      row_q      <= 2'd0;
      rows_q     <= ROW_IDLE;
      cand_q     <= 2'd0;
      cnt_q      <= '0;
      data_q     <= 4'h0;
      dav_q      <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      row_q      <= row_d;
      rows_q     <= rows_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      dav_q      <= dav_d;
    end
  end

  assign rows   = rows_q;
  assign dav    = dav_q;
  assign dataIn = data_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 keypad.
// CLK_DIV=4, DEBOUNCE_TICKS=3; monitor checks every dav rising edge.
module tb_keypad_scanner;

  localparam int CLK_DIV = 4;
  localparam int DBT     = 3;

  logic       clock;
  logic       reset;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       dav;
  logic [3:0] dataIn;

  keypad_scanner #(
    .CLK_DIV       (CLK_DIV),
    .DEBOUNCE_TICKS(DBT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .cols  (cols),
    .rows  (rows),
    .dav   (dav),
    .dataIn(dataIn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] pressed;

  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  logic       dav_prev;
  logic [3:0] data_prev;
  logic [3:0] e;

  initial begin
    dav_prev  = 1'b0;
    data_prev = 4'h0;
  end

  always @(negedge clock) begin
    if (dav && !dav_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dav_pulse: unexpected pulse dataIn=%h, none expected",
                 dataIn);
      end else begin
        e = exp_q.pop_front();
        if (dataIn !== e || data_prev !== e) begin
          errors++;
          $display("FAIL dav_pulse: dataIn=%h prev=%h, required %h",
                   dataIn, data_prev, e);
        end
      end
    end
    dav_prev  <= dav;
    data_prev <= dataIn;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic key(input int r, input int c, input logic dn);
    pressed[r*4+c] = dn;
  endtask

  task automatic wait_dav(input logic lvl, input int budget,
                          input string nm, output int took);
    int n;
    n = 0;
    while (dav !== lvl && n < budget) begin
      @(negedge clock);
      n++;
    end
    took = n;
    checks++;
    if (dav !== lvl) begin
      errors++;
      $display("FAIL %s: dav=%b after %0d clocks, required %b",
               nm, dav, n, lvl);
    end
  endtask

  task automatic hold_check(input logic lvl, input int n,
                            input string nm);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clock);
      if (dav !== lvl) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: dav left %b on %0d clocks, required 0",
               nm, lvl, bad);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] a,
                      input logic [3:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %b, required %b", nm, a, x);
    end
  endtask

  task automatic tap(input int r, input int c, input logic [3:0] code,
                     input string nm);
    int t;
    exp_q.push_back(code);
    key(r, c, 1'b1);
    wait_dav(1'b1, 60, {nm, "_rise"}, t);
    cyc(20);
    key(r, c, 1'b0);
    wait_dav(1'b0, 40, {nm, "_fall"}, t);
    cyc(8);
  endtask

  logic [3:0] exp_rows [4];
  logic [3:0] prev_rows;
  int t;
  int n;

  initial begin
    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    pressed  = '0;
    reset    = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);

    // reset in the middle of HELD
    exp_q.push_back(4'h4);
    key(1, 0, 1'b1);
    wait_dav(1'b1, 60, "rst_pre_rise", t);
    cyc(5);
    #2 reset = 1'b0;
    #1;
    chk4("rst_rows", rows, 4'b1110);
    chk4("rst_dav", {3'b0, dav}, 4'h0);
    chk4("rst_data", dataIn, 4'h0);
    key(1, 0, 1'b0);
    cyc(3);
    reset = 1'b1;
    prev_rows = rows;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (rows == prev_rows && n < 12) begin
        @(negedge clock);
        n++;
      end
      checks++;
      if (rows !== exp_rows[i] || (i > 0 && n != CLK_DIV)) begin
        errors++;
        $display("FAIL rotate%0d: rows=%b gap=%0d, required %b gap=%0d",
                 i, rows, n, exp_rows[i], CLK_DIV);
      end
      prev_rows = rows;
    end

    // clean '5', release timing
    exp_q.push_back(4'h5);
    key(1, 1, 1'b1);
    wait_dav(1'b1, 60, "k5_rise", t);
    hold_check(1'b1, 40, "k5_hold");
    key(1, 1, 1'b0);
    wait_dav(1'b0, 40, "k5_fall", t);
    checks++;
    if (t < 12 || t > 22) begin
      errors++;
      $display("FAIL k5_fall_time: %0d clocks, required 12..22", t);
    end
    cyc(8);

    tap(3, 2, 4'hF, "hash");
    tap(3, 0, 4'hE, "star");

    // bouncing '9' then a release glitch while held
    key(2, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(CLK_DIV);
      pressed[10] = ~pressed[10];
    end
    checks++;
    if (dav !== 1'b0) begin
      errors++;
      $display("FAIL bounce_dav: dav=%b, required 0", dav);
    end
    exp_q.push_back(4'h9);
    key(2, 2, 1'b1);
    wait_dav(1'b1, 60, "k9_rise", t);
    cyc(8);
    key(2, 2, 1'b0);
    cyc(CLK_DIV);
    key(2, 2, 1'b1);
    hold_check(1'b1, 40, "k9_glitch");
    key(2, 2, 1'b0);
    wait_dav(1'b0, 40, "k9_fall", t);
    cyc(8);

    // ghost rejection in row 0
    key(0, 0, 1'b1);
    key(0, 1, 1'b1);
    hold_check(1'b0, 80, "multi_12");
    key(0, 0, 1'b0);
    key(0, 1, 1'b0);
    cyc(8);

    // 'A' held, '7' added
    exp_q.push_back(4'hA);
    key(0, 3, 1'b1);
    wait_dav(1'b1, 60, "kA_rise", t);
    key(2, 0, 1'b1);
    hold_check(1'b1, 60, "kA_hold7");
    chk4("kA_data", dataIn, 4'hA);
    key(2, 0, 1'b0);
    cyc(4);
    key(0, 3, 1'b0);
    wait_dav(1'b0, 40, "kA_fall", t);
    cyc(8);

    tap(0, 2, 4'h3, "k3");
    tap(3, 1, 4'h0, "k0");
    cyc(20);
    chk4("k0_hold_data", dataIn, 4'h0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running, required done");
    $fatal(1, "timeout");
  end

endmodule
